// File: rtl/pc_unit.sv
// Program-counter unit: fetch PC register, sequential increment, branch/jump
// redirect and a circular return-address stack that supplies `ret` targets.
module pc_unit #(
  parameter int unsigned WIDTH        = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned INC          = 4,
  parameter int unsigned RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Write_enable,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus_inc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow,
  output logic             misaligned
);

  localparam int unsigned      PTR_W      = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] RESET_PC   = WIDTH'(RESET_VECTOR);
  localparam logic [WIDTH-1:0] INC_W      = WIDTH'(INC);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d, wr_ptr;
  logic [PTR_W:0]   count_q, count_d;
  logic             underflow_q, underflow_d;
  logic             misaligned_q, misaligned_d;
  logic             pop, push, take_redirect;

  assign pc_out        = pc_q;
  assign pc_plus_inc   = pc_q + INC_W;
  assign ras_empty     = (count_q == '0);
  assign ras_full      = (count_q == FULL_COUNT);
  assign ras_underflow = underflow_q;
  assign misaligned    = misaligned_q;

  // Every request is qualified by Write_enable so a stall freezes all state
  // and lets both pulse flags fall back to 0.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    pop           = Write_enable && ret && !ras_empty;
    push          = Write_enable && call;
    take_redirect = Write_enable && redirect_valid && !pop;
    underflow_d   = Write_enable && ret && ras_empty;
    misaligned_d  = take_redirect && (redirect_target[1:0] != 2'b00);

    pc_d    = pc_q;
    top_d   = top_q;
    count_d = count_q;
    wr_ptr  = top_q + 1'b1;

    if (pop)                pc_d = ras_mem[top_q];
    else if (take_redirect) pc_d = {redirect_target[WIDTH-1:2], 2'b00};
    else if (Write_enable)  pc_d = pc_plus_inc;

    unique case ({push, pop})
      2'b10: begin
        top_d   = top_q + 1'b1;
        count_d = ras_full ? count_q : count_q + 1'b1;
      end
      2'b01: begin
        top_d   = top_q - 1'b1;
        count_d = count_q - 1'b1;
      end
      // Combined call/ret: the pop reads the old top and the push refills that slot.
      2'b11:   wr_ptr = top_q;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from the values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      top_q        <= '0;
      count_q      <= '0;
      underflow_q  <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      top_q        <= top_d;
      count_q      <= count_d;
      underflow_q  <= underflow_d;
      misaligned_q <= misaligned_d;
    end
  end

  // NOTE: the stack storage is deliberately left out of reset; count gates
  // every read, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (push) ras_mem[wr_ptr] <= pc_plus_inc;
  end

endmodule
